// File: rtl/rlnn_step_sequencer.sv
// Step sequencer for the RL network wrapper: latches one sample, runs model/target forward passes and training.
// Optional macro RLNN_SEQ_TIMEOUT_EN adds a per-phase watchdog that parks the FSM in ERROR until reset.
module rlnn_step_sequencer #(
  parameter int DATA_WIDTH         = 4,
  parameter int NEURON_INPUT_LAYER = 2,
  parameter int TARGET_SYNC_PERIOD = 4,
  parameter int TIMEOUT_CYCLES     = 255,
  parameter int STEP_CNT_WIDTH     = 16
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     sample_valid,
  output logic                                     sample_ready,
  input  logic [NEURON_INPUT_LAYER*DATA_WIDTH-1:0] sample_data,
  input  logic                                     train_mode,
  output logic [NEURON_INPUT_LAYER*DATA_WIDTH-1:0] nn_input,
  output logic                                     input_enable,
  output logic                                     use_target,
  output logic                                     is_training,
  input  logic                                     model_fwd_done,
  input  logic                                     target_fwd_done,
  input  logic                                     training_done,
  output logic                                     target_sync,
  output logic                                     step_done,
  output logic                                     busy,
  output logic [STEP_CNT_WIDTH-1:0]                step_count,
  output logic                                     error
);

  localparam int VEC_W = NEURON_INPUT_LAYER * DATA_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE, S_MODEL_FWD, S_TARGET_FWD, S_TRAIN, S_SYNC, S_FINISH, S_ERROR
  } state_t;

  state_t                    r_state;
  state_t                    w_next;
  logic                      r_mode;
  logic [VEC_W-1:0]          r_nn_input;
  logic [STEP_CNT_WIDTH-1:0] r_step_count;
  logic [6:0]                r_ctrl;
  logic [STEP_CNT_WIDTH-1:0] w_cnt_inc;
  logic                      w_sync_due;
  logic                      w_timeout;

  // Control word order: {sample_ready, input_enable, use_target, is_training, target_sync, step_done, busy}
  function automatic logic [6:0] ctrl_of(input state_t s);
    case (s)
      S_IDLE:       ctrl_of = 7'b1000000;
      S_MODEL_FWD:  ctrl_of = 7'b0100001;
      S_TARGET_FWD: ctrl_of = 7'b0110001;
      S_TRAIN:      ctrl_of = 7'b0001001;
      S_SYNC:       ctrl_of = 7'b0000101;
      S_FINISH:     ctrl_of = 7'b0000011;
      default:      ctrl_of = 7'b0000001;
    endcase
  endfunction

  assign w_cnt_inc  = r_step_count + STEP_CNT_WIDTH'(1);
  assign w_sync_due = (w_cnt_inc % STEP_CNT_WIDTH'(TARGET_SYNC_PERIOD)) == '0;

`ifdef RLNN_SEQ_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] r_wait;
  logic            r_error;

  // Timeout fires on the last permitted wait cycle; a matching done in that cycle takes priority.
  assign w_timeout = (r_wait == TO_W'(TIMEOUT_CYCLES - 1));
  assign error     = r_error;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait  <= '0;
      r_error <= 1'b0;
    end else begin
      if (w_next != r_state)
        r_wait <= '0;
      else if (r_state == S_MODEL_FWD || r_state == S_TARGET_FWD || r_state == S_TRAIN)
        r_wait <= r_wait + TO_W'(1);
      if (w_next == S_ERROR)
        r_error <= 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
  // Constant 0 for any legal TIMEOUT_CYCLES; ERROR is unreachable in this build.
  assign error     = (TIMEOUT_CYCLES < 1);
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:       if (sample_valid) w_next = S_MODEL_FWD;
      S_MODEL_FWD:  if (model_fwd_done) w_next = r_mode ? S_TARGET_FWD : S_FINISH;
                    else if (w_timeout) w_next = S_ERROR;
      S_TARGET_FWD: if (target_fwd_done) w_next = S_TRAIN;
                    else if (w_timeout) w_next = S_ERROR;
      S_TRAIN:      if (training_done) w_next = w_sync_due ? S_SYNC : S_FINISH;
                    else if (w_timeout) w_next = S_ERROR;
      S_SYNC:       w_next = S_FINISH;
      S_FINISH:     w_next = S_IDLE;
      default:      w_next = S_ERROR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_mode       <= 1'b0;
      r_nn_input   <= '0;
      r_step_count <= '0;
      r_ctrl       <= ctrl_of(S_IDLE);
    end else begin
      r_state <= w_next;
      r_ctrl  <= ctrl_of(w_next);
      if (r_state == S_IDLE && sample_valid) begin
        r_nn_input <= sample_data;
        r_mode     <= train_mode;
      end
      if (r_state == S_TRAIN && training_done)
        r_step_count <= w_cnt_inc;
    end
  end

  assign {sample_ready, input_enable, use_target, is_training, target_sync, step_done, busy} = r_ctrl;
  assign nn_input   = r_nn_input;
  assign step_count = r_step_count;

endmodule

// File: tb/tb_rlnn_step_sequencer.sv
// Directed testbench for rlnn_step_sequencer: inference, training, target sync, spurious done, reset and timeout.
// The timeout scenario is exercised when RLNN_SEQ_TIMEOUT_EN is defined for both bench and RTL.
module tb_rlnn_step_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sample_valid = 1'b0;
  logic        sample_ready;
  logic [7:0]  sample_data = 8'h00;
  logic        train_mode = 1'b0;
  logic [7:0]  nn_input;
  logic        input_enable, use_target, is_training;
  logic        model_fwd_done = 1'b0, target_fwd_done = 1'b0, training_done = 1'b0;
  logic        target_sync, step_done, busy, error;
  logic [15:0] step_count;

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] exp_count = 16'd0;

  rlnn_step_sequencer #(
    .DATA_WIDTH(4), .NEURON_INPUT_LAYER(2), .TARGET_SYNC_PERIOD(4),
    .TIMEOUT_CYCLES(10), .STEP_CNT_WIDTH(16)
  ) dut (
    .clk(clk), .rst(rst),
    .sample_valid(sample_valid), .sample_ready(sample_ready),
    .sample_data(sample_data), .train_mode(train_mode),
    .nn_input(nn_input), .input_enable(input_enable),
    .use_target(use_target), .is_training(is_training),
    .model_fwd_done(model_fwd_done), .target_fwd_done(target_fwd_done),
    .training_done(training_done), .target_sync(target_sync),
    .step_done(step_done), .busy(busy), .step_count(step_count), .error(error)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    n_vec++; if ({input_enable, use_target, is_training, target_sync, step_done, busy, error} !== 7'b0) begin
      n_err++; $display("FAIL reset_ctrl: got %b expected 0000000",
        {input_enable, use_target, is_training, target_sync, step_done, busy, error}); end
    n_vec++; if (sample_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b expected 1", sample_ready); end
    n_vec++; if (nn_input !== 8'h00) begin n_err++; $display("FAIL reset_nn_input: got %h expected 00", nn_input); end
    n_vec++; if (step_count !== 16'd0) begin n_err++; $display("FAIL reset_count: got %0d expected 0", step_count); end
    rst = 1'b0;
    exp_count = 16'd0;
    tick();
  endtask

  task automatic test_inference();
    int   n_done;
    logic bad_ctrl;
    n_done = 0; bad_ctrl = 1'b0;
    sample_data = 8'h21; train_mode = 1'b0; sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0; sample_data = 8'hFF;
    n_vec++; if (input_enable !== 1'b1) begin n_err++; $display("FAIL inf_ie_rise: got %b expected 1", input_enable); end
    n_vec++; if (nn_input !== 8'h21) begin n_err++; $display("FAIL inf_nn_input: got %h expected 21", nn_input); end
    n_vec++; if ({sample_ready, busy} !== 2'b01) begin n_err++; $display("FAIL inf_ready_busy: got %b expected 01", {sample_ready, busy}); end
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (input_enable !== 1'b1 || use_target !== 1'b0 || is_training !== 1'b0) bad_ctrl = 1'b1;
      if (step_done === 1'b1) n_done++;
    end
    model_fwd_done = 1'b1;
    tick();
    model_fwd_done = 1'b0;
    n_vec++; if ({input_enable, step_done} !== 2'b01) begin n_err++; $display("FAIL inf_finish: ie,step_done got %b expected 01", {input_enable, step_done}); end
    if (step_done === 1'b1) n_done++;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (use_target !== 1'b0 || is_training !== 1'b0 || input_enable !== 1'b0) bad_ctrl = 1'b1;
      if (step_done === 1'b1) n_done++;
    end
    n_vec++; if (bad_ctrl !== 1'b0) begin n_err++; $display("FAIL inf_ctrl_seq: bad control seen got %b expected 0", bad_ctrl); end
    n_vec++; if (n_done != 1) begin n_err++; $display("FAIL inf_step_done_count: got %0d expected 1", n_done); end
    n_vec++; if (step_count !== exp_count) begin n_err++; $display("FAIL inf_count: got %0d expected %0d", step_count, exp_count); end
    n_vec++; if ({sample_ready, nn_input} !== {1'b1, 8'h21}) begin n_err++; $display("FAIL inf_hold: ready,nn_input got %b,%h expected 1,21", sample_ready, nn_input); end
  endtask

  task automatic test_training();
    logic bad;
    bad = 1'b0;
    sample_data = 8'h12; train_mode = 1'b1; sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0; train_mode = 1'b0;
    n_vec++; if (nn_input !== 8'h12) begin n_err++; $display("FAIL trn_nn_input: got %h expected 12", nn_input); end
    for (int i = 0; i < 3; i++) begin
      if ({input_enable, use_target, is_training} !== 3'b100) bad = 1'b1;
      if (i == 2) model_fwd_done = 1'b1;
      tick();
    end
    model_fwd_done = 1'b0;
    n_vec++; if (bad !== 1'b0) begin n_err++; $display("FAIL trn_model_phase: bad control got %b expected 0", bad); end
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if ({input_enable, use_target, is_training} !== 3'b110) bad = 1'b1;
      if (i == 2) target_fwd_done = 1'b1;
      tick();
    end
    target_fwd_done = 1'b0;
    n_vec++; if (bad !== 1'b0) begin n_err++; $display("FAIL trn_target_phase: bad control got %b expected 0", bad); end
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if ({input_enable, use_target, is_training} !== 3'b001) bad = 1'b1;
      if (step_count !== exp_count) bad = 1'b1;
      if (i == 2) training_done = 1'b1;
      tick();
    end
    training_done = 1'b0;
    exp_count = exp_count + 16'd1;
    n_vec++; if (bad !== 1'b0) begin n_err++; $display("FAIL trn_train_phase: bad control got %b expected 0", bad); end
    n_vec++; if ({target_sync, step_done, is_training} !== 3'b010) begin n_err++; $display("FAIL trn_finish: sync,done,train got %b expected 010", {target_sync, step_done, is_training}); end
    n_vec++; if (step_count !== exp_count) begin n_err++; $display("FAIL trn_count: got %0d expected %0d", step_count, exp_count); end
    tick();
    n_vec++; if ({sample_ready, step_done, target_sync} !== 3'b100) begin n_err++; $display("FAIL trn_idle: ready,done,sync got %b expected 100", {sample_ready, step_done, target_sync}); end
  endtask

  task automatic test_spurious_done();
    sample_data = 8'h5A; train_mode = 1'b1; sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    training_done = 1'b1; target_fwd_done = 1'b1;
    tick();
    training_done = 1'b0; target_fwd_done = 1'b0;
    tick();
    n_vec++; if ({input_enable, use_target, is_training, busy} !== 4'b1001) begin n_err++; $display("FAIL spur_model_hold: ctrl got %b expected 1001", {input_enable, use_target, is_training, busy}); end
    n_vec++; if (step_count !== exp_count) begin n_err++; $display("FAIL spur_count_hold: got %0d expected %0d", step_count, exp_count); end
    model_fwd_done = 1'b1; training_done = 1'b1;
    tick();
    model_fwd_done = 1'b0; training_done = 1'b0;
    n_vec++; if ({input_enable, use_target, is_training} !== 3'b110) begin n_err++; $display("FAIL spur_multi_done: ctrl got %b expected 110", {input_enable, use_target, is_training}); end
    model_fwd_done = 1'b1; training_done = 1'b1;
    tick();
    model_fwd_done = 1'b0; training_done = 1'b0;
    n_vec++; if ({input_enable, use_target, is_training, step_count} !== {3'b110, exp_count}) begin n_err++; $display("FAIL spur_target_hold: ctrl got %b count %0d expected 110 count %0d", {input_enable, use_target, is_training}, step_count, exp_count); end
    target_fwd_done = 1'b1;
    tick();
    target_fwd_done = 1'b0;
    training_done = 1'b1;
    tick();
    training_done = 1'b0;
    exp_count = exp_count + 16'd1;
    n_vec++; if ({step_done, step_count} !== {1'b1, exp_count}) begin n_err++; $display("FAIL spur_complete: done %b count %0d expected 1 count %0d", step_done, step_count, exp_count); end
    tick();
  endtask

  task automatic test_reset_mid_step();
    int n_done;
    n_done = 0;
    sample_data = 8'h77; train_mode = 1'b1; sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    model_fwd_done = 1'b1;
    tick();
    model_fwd_done = 1'b0;
    n_vec++; if (use_target !== 1'b1) begin n_err++; $display("FAIL rstmid_in_target: use_target got %b expected 1", use_target); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_count = 16'd0;
    n_vec++; if ({input_enable, use_target, is_training, target_sync, step_done, busy, error} !== 7'b0) begin
      n_err++; $display("FAIL rstmid_ctrl: got %b expected 0000000",
        {input_enable, use_target, is_training, target_sync, step_done, busy, error}); end
    n_vec++; if ({sample_ready, nn_input, step_count} !== {1'b1, 8'h00, 16'd0}) begin n_err++; $display("FAIL rstmid_state: ready %b nn %h count %0d expected 1 00 0", sample_ready, nn_input, step_count); end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (step_done === 1'b1) n_done++;
    end
    n_vec++; if (n_done != 0) begin n_err++; $display("FAIL rstmid_no_done: step_done pulses got %0d expected 0", n_done); end
  endtask

  task automatic do_step(input logic [7:0] d, output int n_sync, output logic sync_before_done, output logic done_seen);
    logic prev_sync;
    n_sync = 0; sync_before_done = 1'b0; done_seen = 1'b0; prev_sync = 1'b0;
    sample_data = d; train_mode = 1'b1; sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    repeat (2) tick();
    model_fwd_done = 1'b1;  tick(); model_fwd_done = 1'b0;
    repeat (2) tick();
    target_fwd_done = 1'b1; tick(); target_fwd_done = 1'b0;
    repeat (2) tick();
    training_done = 1'b1;   tick(); training_done = 1'b0;
    for (int i = 0; i < 4 && !done_seen; i++) begin
      if (target_sync === 1'b1) n_sync++;
      if (step_done === 1'b1) begin
        done_seen = 1'b1;
        sync_before_done = prev_sync;
      end
      prev_sync = target_sync;
      tick();
    end
  endtask

  task automatic test_target_sync();
    int   n_sync;
    logic sbd, dseen;
    rst = 1'b1; tick(); rst = 1'b0; tick();
    exp_count = 16'd0;
    for (int s = 1; s <= 8; s++) begin
      do_step(8'h30 + 8'(s), n_sync, sbd, dseen);
      exp_count = exp_count + 16'd1;
      n_vec++; if (dseen !== 1'b1) begin n_err++; $display("FAIL sync_step%0d_done: step_done seen %b expected 1", s, dseen); end
      n_vec++; if (n_sync != ((s % 4 == 0) ? 1 : 0)) begin n_err++; $display("FAIL sync_step%0d_pulses: got %0d expected %0d", s, n_sync, (s % 4 == 0) ? 1 : 0); end
      if (s % 4 == 0) begin
        n_vec++; if (sbd !== 1'b1) begin n_err++; $display("FAIL sync_step%0d_order: sync before done got %b expected 1", s, sbd); end
      end
      n_vec++; if (sample_ready !== 1'b1) begin n_err++; $display("FAIL sync_step%0d_ready: got %b expected 1", s, sample_ready); end
    end
    n_vec++; if (step_count !== 16'd8) begin n_err++; $display("FAIL sync_count: got %0d expected 8", step_count); end
  endtask

`ifdef RLNN_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    sample_data = 8'h44; train_mode = 1'b0; sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    repeat (9) tick();
    n_vec++; if ({error, input_enable} !== 2'b01) begin n_err++; $display("FAIL to_before: error,ie got %b expected 01", {error, input_enable}); end
    model_fwd_done = 1'b1;
    tick();
    model_fwd_done = 1'b0;
    n_vec++; if ({error, step_done} !== 2'b01) begin n_err++; $display("FAIL to_done_wins: error,step_done got %b expected 01", {error, step_done}); end
    tick();
    sample_data = 8'h99; sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    repeat (9) tick();
    n_vec++; if ({error, input_enable} !== 2'b01) begin n_err++; $display("FAIL to_cycle10: error,ie got %b expected 01", {error, input_enable}); end
    tick();
    n_vec++; if ({error, input_enable, sample_ready, busy} !== 4'b1001) begin n_err++; $display("FAIL to_error: err,ie,ready,busy got %b expected 1001", {error, input_enable, sample_ready, busy}); end
    sample_data = 8'hAB; sample_valid = 1'b1;
    repeat (3) tick();
    sample_valid = 1'b0;
    n_vec++; if ({error, sample_ready, input_enable, nn_input} !== {3'b100, 8'h99}) begin n_err++; $display("FAIL to_refuse: err,ready,ie %b nn %h expected 100 99", {error, sample_ready, input_enable}, nn_input); end
    rst = 1'b1; tick(); rst = 1'b0;
    n_vec++; if ({error, sample_ready, busy} !== 3'b010) begin n_err++; $display("FAIL to_rst_clear: err,ready,busy got %b expected 010", {error, sample_ready, busy}); end
  endtask
`else
  task automatic test_timeout();
    sample_data = 8'h44; train_mode = 1'b0; sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    repeat (20) tick();
    n_vec++; if ({error, input_enable, busy} !== 3'b011) begin n_err++; $display("FAIL nto_wait: err,ie,busy got %b expected 011", {error, input_enable, busy}); end
    model_fwd_done = 1'b1;
    tick();
    model_fwd_done = 1'b0;
    n_vec++; if ({error, step_done} !== 2'b01) begin n_err++; $display("FAIL nto_finish: err,done got %b expected 01", {error, step_done}); end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_inference();
    test_training();
    test_spurious_done();
    test_reset_mid_step();
    test_target_sync();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
